key_debounce: RTL and testbench

Front-end conditioning stage for the board push-button that drives the LED flasher's active-low reset input. Synchronises the raw mechanical key into the `sclk` domain, rejects contact bounce with a stable-time filter, and produces a clean debounced level plus single-cycle press/release strobes. `key_n_out` connects directly to the flasher's `rst_n`. The strobes serve any future mode/control logic.

---
 rtl/key_debounce.sv | 89 ++++++++
 tb/tb_key_debounce.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-time bounce filter,
// registered debounced level plus one-cycle press/release strobes.
module key_debounce #(
  parameter int DEB_CNT = 999999,
  parameter int CNT_W   = 20
) (
  input  logic sclk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_n_out,
  output logic key_press,
  output logic key_release
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_FILT = 2'd1;
  localparam logic [1:0] DOWN       = 2'd2;
  localparam logic [1:0] REL_FILT   = 2'd3;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CNT);

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // key_n_out is kept as its own flop so the flasher reset is glitch-free.
  always_ff @(posedge sclk) begin
    if (rst) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_n_out   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_in;
      s2          <= s1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!s2) state <= PRESS_FILT;
        end
        PRESS_FILT: begin
          if (s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state     <= DOWN;
            cnt       <= '0;
            key_level <= 1'b1;
            key_n_out <= 1'b0;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          cnt <= '0;
          if (s2) state <= REL_FILT;
        end
        REL_FILT: begin
          if (!s2) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_n_out   <= 1'b1;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected strobes with
// their cycle numbers, a negedge monitor pops and checks every strobe seen.
module tb_key_debounce;

  localparam int DEB = 9;
  localparam int LAT = DEB + 4;

  logic sclk;
  logic rst;
  logic key_in;
  logic key_level;
  logic key_n_out;
  logic key_press;
  logic key_release;

  typedef struct {
    bit rel;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   armed    = 0;

  key_debounce #(.DEB_CNT(DEB), .CNT_W(4)) dut (
    .sclk        (sclk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_n_out   (key_n_out),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic val, input int n);
    key_in = val;
    repeat (n) @(negedge sclk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void pushExp(input bit rel, input int at);
    exp_t e;
    e.rel = rel;
    e.cyc = at;
    expQ.push_back(e);
  endfunction

  // Any strobe not announced by the stimulus is an error, so missing
  // rejections, double pulses and spurious releases all surface here.
  always @(negedge sclk) begin
    exp_t e;
    if (armed) begin
      checks++;
      if (key_n_out !== ~key_level) begin
        failures++;
        $display("[TB] FAIL n_out_inv: key_n_out=%b key_level=%b (cycle %0d)", key_n_out, key_level, cyc);
      end
      if (key_press === 1'b1 || key_release === 1'b1) begin
        checks++;
        if (key_press && key_release) begin
          failures++;
          $display("[TB] FAIL both_strobes: press=1 release=1, expected at most one (cycle %0d)", cyc);
        end else if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_strobe: press=%b release=%b, expected none (cycle %0d)", key_press, key_release, cyc);
        end else begin
          e = expQ.pop_front();
          if (e.rel !== key_release || e.cyc != cyc || key_level !== !e.rel) begin
            failures++;
            $display("[TB] FAIL strobe: release=%b cycle=%0d level=%b, expected release=%b cycle=%0d level=%b",
                     key_release, cyc, key_level, e.rel, e.cyc, !e.rel);
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    key_in = 1'b1;
    repeat (3) @(negedge sclk);
    checkOutput("rst_level", int'(key_level), 0);
    checkOutput("rst_n_out", int'(key_n_out), 1);
    checkOutput("rst_press", int'(key_press), 0);
    checkOutput("rst_release", int'(key_release), 0);
    rst   = 1'b0;
    armed = 1'b1;
    applyStimulus(1'b1, 50);

    // clean press and release
    pushExp(1'b0, cyc + LAT);
    applyStimulus(1'b0, 20);
    checkOutput("clean_level_hi", int'(key_level), 1);
    checkOutput("clean_n_out_lo", int'(key_n_out), 0);
    applyStimulus(1'b0, 20);
    pushExp(1'b1, cyc + LAT);
    applyStimulus(1'b1, 30);
    checkOutput("clean_level_lo", int'(key_level), 0);

    // glitch boundary: 10 edges rejected, 11 accepted
    applyStimulus(1'b0, DEB + 1);
    applyStimulus(1'b1, 30);
    checkOutput("glitch10_level", int'(key_level), 0);
    pushExp(1'b0, cyc + LAT);
    pushExp(1'b1, cyc + DEB + 2 + LAT);
    applyStimulus(1'b0, DEB + 2);
    applyStimulus(1'b1, 30);
    checkOutput("glitch11_level", int'(key_level), 0);

    // bounce: 3-cycle toggles, then stable low
    for (int i = 0; i < 10; i++) applyStimulus(logic'(i % 2), 3);
    pushExp(1'b0, cyc + LAT);
    applyStimulus(1'b0, 30);
    checkOutput("bounce_level", int'(key_level), 1);
    pushExp(1'b1, cyc + LAT);
    applyStimulus(1'b1, 30);

    // reset while held: no release, press refiltered after rst drops
    pushExp(1'b0, cyc + LAT);
    applyStimulus(1'b0, LAT + 2);
    rst = 1'b1;
    @(negedge sclk);
    checkOutput("midrst_level", int'(key_level), 0);
    checkOutput("midrst_n_out", int'(key_n_out), 1);
    rst = 1'b0;
    pushExp(1'b0, cyc + LAT);
    applyStimulus(1'b0, 30);
    checkOutput("midrst_level_again", int'(key_level), 1);
    pushExp(1'b1, cyc + LAT);
    applyStimulus(1'b1, 30);

    // long hold: single press, level stays up
    pushExp(1'b0, cyc + LAT);
    applyStimulus(1'b0, LAT);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 17);
      checkOutput("hold_level", int'(key_level), 1);
    end
    pushExp(1'b1, cyc + LAT);
    applyStimulus(1'b1, 30);

    checkOutput("sb_pending", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
